// File: rtl/bram_led_player.sv
// bram_led_player: a button press (or an autoplay tick) picks a BRAM word; it is read and latched onto the LEDs.
// Latency: request accepted in IDLE at t -> bram_en at t+1 -> leds valid from t+2+RD_LATENCY.
// Backpressure: none; a request arriving while busy overwrites the single pending slot (newest wins).
// Build option: define BRAM_LED_PLAYER_AUTOPLAY_EN for the autoplay timer; otherwise mode is ignored.
module bram_led_player #(
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 4,
  parameter int N_BTN       = 4,
  parameter int RD_LATENCY  = 1,
  parameter int STEP_CYCLES = 125_000_000,
  parameter int LAST_ADDR   = 2**ADDR_W - 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_BTN-1:0]  btn,
  input  logic              mode,
  output logic              bram_en,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [DATA_W-1:0] bram_dout,
  output logic [DATA_W-1:0] leds,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CAPTURE} state_t;
  state_t state, state_nxt;

  logic [N_BTN-1:0]  btn_s1, btn_s2, btn_d;
  logic [N_BTN-1:0]  btn_rise;
  logic              btn_hit;
  logic [ADDR_W-1:0] btn_addr;
  logic              tick;
  logic [ADDR_W-1:0] tick_addr;
  logic              req_vld;
  logic [ADDR_W-1:0] req_addr;
  logic              pend_vld;
  logic [ADDR_W-1:0] pend_addr;
  logic              take;
  logic [ADDR_W-1:0] take_addr;
  logic [ADDR_W-1:0] cur_addr;
  logic [1:0]        wait_cnt;
  logic              wait_done;

  // Two-flop synchroniser plus one delay stage for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_s1 <= '0;
      btn_s2 <= '0;
      btn_d  <= '0;
    end else begin
      btn_s1 <= btn;
      btn_s2 <= btn_s1;
      btn_d  <= btn_s2;
    end
  end

  assign btn_rise = btn_s2 & ~btn_d;

  // Pick the lowest-index rising edge; the rest of a simultaneous group is dropped.
  always_comb begin
    btn_hit  = 1'b0;
    btn_addr = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (btn_rise[i]) begin
        btn_hit  = 1'b1;
        btn_addr = ADDR_W'(i);
      end
    end
  end

  // Autoplay steps from the most recently issued address and wraps after LAST_ADDR.
  assign tick_addr = (cur_addr == ADDR_W'(LAST_ADDR)) ? '0 : cur_addr + ADDR_W'(1);

`ifdef BRAM_LED_PLAYER_AUTOPLAY_EN
  localparam int TMR_W = $clog2(STEP_CYCLES);
  logic [TMR_W-1:0] timer;

  // Step timer: held at zero in direct mode, restarted by any press, ticks at terminal count.
  always_ff @(posedge clk) begin
    if (rst || !mode || btn_hit) begin
      timer <= '0;
    end else if (timer == TMR_W'(STEP_CYCLES - 1)) begin
      timer <= '0;
    end else begin
      timer <= timer + TMR_W'(1);
    end
  end

  assign tick = mode && (timer == TMR_W'(STEP_CYCLES - 1));
`else
  logic unused_mode;
  assign unused_mode = mode & (STEP_CYCLES >= 2);
  assign tick        = 1'b0;
`endif

  // A button always beats a same-cycle tick.
  assign req_vld   = btn_hit | tick;
  assign req_addr  = btn_hit ? btn_addr : tick_addr;

  // In IDLE a live request bypasses the pending slot, since it is the newest one.
  assign take      = (state == IDLE) && (req_vld || pend_vld);
  assign take_addr = req_vld ? req_addr : pend_addr;
  assign wait_done = (wait_cnt == 2'(RD_LATENCY - 2));

  // Pending slot, issued address, wait counter and LED register; reset queues a read of word 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_vld  <= 1'b1;
      pend_addr <= '0;
      cur_addr  <= '0;
      wait_cnt  <= '0;
      leds      <= '0;
    end else begin
      if (take) begin
        pend_vld <= 1'b0;
        cur_addr <= take_addr;
      end else if (req_vld) begin
        pend_vld  <= 1'b1;
        pend_addr <= req_addr;
      end
      wait_cnt <= (state == WAIT) ? wait_cnt + 2'd1 : 2'd0;
      if (state == CAPTURE) begin
        leds <= bram_dout;
      end
    end
  end

  // FSM state register; reset abandons any read in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and read-port strobes.
  always_comb begin
    state_nxt = state;
    bram_en   = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (take) state_nxt = ISSUE;
      end
      ISSUE: begin
        bram_en   = 1'b1;
        state_nxt = (RD_LATENCY == 1) ? CAPTURE : WAIT;
      end
      WAIT: begin
        if (wait_done) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign bram_addr = cur_addr;

endmodule

// File: tb/tb_bram_led_player.sv
// Bench for bram_led_player: two instances (read latency 1 and 3) share the stimulus.
// A transaction-level model predicts reads, LEDs and busy windows from cycle arithmetic.
// Directed scenarios first, then a randomized run with occasional resets and mode flips.
module tb_bram_led_player;
  localparam int STEP = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn;
  logic       mode;

  logic       en_l1, en_l3, busy_l1, busy_l3;
  logic [3:0] addr_l1, addr_l3, dout_l1, dout_l3, leds_l1, leds_l3;

  always #5 clk = ~clk;

  bram_led_player #(.RD_LATENCY(1), .STEP_CYCLES(STEP)) u_l1 (
    .clk(clk), .rst(rst), .btn(btn), .mode(mode), .bram_en(en_l1), .bram_addr(addr_l1),
    .bram_dout(dout_l1), .leds(leds_l1), .busy(busy_l1));

  bram_led_player #(.RD_LATENCY(3), .STEP_CYCLES(STEP)) u_l3 (
    .clk(clk), .rst(rst), .btn(btn), .mode(mode), .bram_en(en_l3), .bram_addr(addr_l3),
    .bram_dout(dout_l3), .leds(leds_l3), .busy(busy_l3));

  function automatic logic [3:0] word(input logic [3:0] k);
    return 4'(int'(k) * 3 + 1);
  endfunction

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  // BRAM models: delay lines of the read latency.
  logic [3:0] p1;
  logic [3:0] p3 [3];
  always @(posedge clk) begin
    if (en_l1) p1 <= word(addr_l1);
    if (en_l3) p3[0] <= word(addr_l3);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign dout_l1 = p1;
  assign dout_l3 = p3[2];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  // Reference model state (per instance where it differs).
  bit         valid = 1'b0;
  int         cyc = 0;
  logic [3:0] b1 = '0, b2 = '0, b3 = '0;
  int         cnt = 0;
  int         en_cyc [2];
  int         done_cyc [2];
  logic [3:0] acc_a [2];
  logic [3:0] prev_a [2];
  logic [3:0] led_new [2];
  logic [3:0] led_old [2];
  logic [3:0] pend_a [2];
  bit         pend_v [2];
  int         rd_cnt [2];
  logic [3:0] rd_last [2];
  logic [3:0] rd_prev [2];

  function automatic logic [3:0] leds_of(input int k);
    return (k == 0) ? leds_l1 : leds_l3;
  endfunction

  function automatic logic busy_of(input int k);
    return (k == 0) ? busy_l1 : busy_l3;
  endfunction

  function automatic logic en_of(input int k);
    return (k == 0) ? en_l1 : en_l3;
  endfunction

  // Decide what each instance does with this cycle's inputs.
  task automatic model_step(input logic [3:0] b, input bit r);
    logic [3:0] rise, ba, ra;
    bit         hit, tk, rq;
    rise = b2 & ~b3;
    hit  = 1'b0;
    ba   = '0;
    for (int i = 0; i < 4; i++) begin
      if (rise[i] && !hit) begin
        hit = 1'b1;
        ba  = 4'(i);
      end
    end
    if (r) begin
      valid = 1'b1;
      cnt   = 0;
      for (int k = 0; k < 2; k++) begin
        en_cyc[k] = -100; done_cyc[k] = -100;
        acc_a[k] = '0; prev_a[k] = '0; led_new[k] = '0; led_old[k] = '0;
        pend_v[k] = 1'b1; pend_a[k] = '0;
      end
    end else begin
`ifdef BRAM_LED_PLAYER_AUTOPLAY_EN
      tk  = mode && (cnt % STEP == STEP - 1);
      cnt = (!mode || hit) ? 0 : cnt + 1;
`else
      tk = 1'b0;
`endif
      for (int k = 0; k < 2; k++) begin
        rq = hit || tk;
        ra = hit ? ba : 4'((int'(acc_a[k]) + 1) % 16);
        if (cyc >= done_cyc[k]) begin
          if (rq || pend_v[k]) begin
            prev_a[k]   = acc_a[k];
            led_old[k]  = led_new[k];
            acc_a[k]    = rq ? ra : pend_a[k];
            led_new[k]  = word(acc_a[k]);
            en_cyc[k]   = cyc + 1;
            done_cyc[k] = cyc + 2 + lat(k);
            pend_v[k]   = 1'b0;
          end
        end else if (rq) begin
          pend_v[k] = 1'b1;
          pend_a[k] = ra;
        end
      end
    end
    b3 = b2;
    b2 = b1;
    b1 = b;
  endtask

  task automatic check_inst(input int k, input logic e, input logic [3:0] a,
                            input logic [3:0] l, input logic bz);
    check($sformatf("bram_en_L%0d", lat(k)), int'(e), int'(cyc == en_cyc[k]));
    check($sformatf("bram_addr_L%0d", lat(k)), int'(a),
          int'((cyc >= en_cyc[k]) ? acc_a[k] : prev_a[k]));
    check($sformatf("leds_L%0d", lat(k)), int'(l),
          int'((cyc >= done_cyc[k]) ? led_new[k] : led_old[k]));
    check($sformatf("busy_L%0d", lat(k)), int'(bz),
          int'(cyc >= en_cyc[k] && cyc < done_cyc[k]));
    if (e) begin
      rd_cnt[k]++;
      rd_prev[k] = rd_last[k];
      rd_last[k] = a;
    end
  endtask

  task automatic run_cycle(input logic [3:0] b, input bit r, input bit md);
    btn  = b;
    rst  = r;
    mode = md;
    model_step(b, r);
    @(posedge clk);
    #1;
    cyc++;
    if (valid) begin
      check_inst(0, en_l1, addr_l1, leds_l1, busy_l1);
      check_inst(1, en_l3, addr_l3, leds_l3, busy_l3);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         base [2];
    logic [3:0] rb;
    bit         md;
    for (int k = 0; k < 2; k++) begin
      rd_cnt[k] = 0; rd_last[k] = '0; rd_prev[k] = '0;
    end

    // Reset release with idle buttons: one read of word 0.
    repeat (3) run_cycle(4'b0000, 1'b1, 1'b0);
    repeat (8) run_cycle(4'b0000, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      check("reset_reads", rd_cnt[k], 1);
      check("reset_addr", int'(rd_last[k]), 0);
      check("reset_leds", int'(leds_of(k)), 1);
      check("reset_busy", int'(busy_of(k)), 0);
    end

    // Held button: a single read.
    for (int k = 0; k < 2; k++) base[k] = rd_cnt[k];
    repeat (20) run_cycle(4'b0100, 1'b0, 1'b0);
    repeat (8) run_cycle(4'b0000, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      check("held_reads", rd_cnt[k] - base[k], 1);
      check("held_addr", int'(rd_last[k]), 2);
      check("held_leds", int'(leds_of(k)), 7);
    end

    // Simultaneous edges: lowest index wins.
    for (int k = 0; k < 2; k++) base[k] = rd_cnt[k];
    repeat (3) run_cycle(4'b1010, 1'b0, 1'b0);
    repeat (10) run_cycle(4'b0000, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      check("simul_reads", rd_cnt[k] - base[k], 1);
      check("simul_addr", int'(rd_last[k]), 1);
      check("simul_leds", int'(leds_of(k)), 4);
    end

    // Second press while busy lands in the pending slot.
    for (int k = 0; k < 2; k++) base[k] = rd_cnt[k];
    run_cycle(4'b1000, 1'b0, 1'b0);
    repeat (5) run_cycle(4'b1001, 1'b0, 1'b0);
    repeat (12) run_cycle(4'b0000, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      check("pend_reads", rd_cnt[k] - base[k], 2);
      check("pend_first", int'(rd_prev[k]), 3);
      check("pend_second", int'(rd_last[k]), 0);
      check("pend_leds", int'(leds_of(k)), 1);
    end

    // Reset while the latency-3 instance waits for data.
    run_cycle(4'b0010, 1'b0, 1'b0);
    repeat (3) run_cycle(4'b0000, 1'b0, 1'b0);
    check("midread_busy", int'(busy_l3), 1);
    run_cycle(4'b0000, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      check("midread_leds", int'(leds_of(k)), 0);
      check("midread_en", int'(en_of(k)), 0);
      base[k] = rd_cnt[k];
    end
    repeat (10) run_cycle(4'b0000, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      check("post_rst_reads", rd_cnt[k] - base[k], 1);
      check("post_rst_addr", int'(rd_last[k]), 0);
      check("post_rst_leds", int'(leds_of(k)), 1);
    end

`ifdef BRAM_LED_PLAYER_AUTOPLAY_EN
    // Autoplay walks up to LAST_ADDR, then wraps to 0.
    for (int i = 0; i < 400 && rd_last[0] != 4'd15; i++) run_cycle(4'b0000, 1'b0, 1'b1);
    check("ap_reach15", int'(rd_last[0]), 15);
    base[0] = rd_cnt[0];
    for (int i = 0; i < 40 && rd_cnt[0] == base[0]; i++) run_cycle(4'b0000, 1'b0, 1'b1);
    check("ap_wrap_addr", int'(rd_last[0]), 0);
    repeat (6) run_cycle(4'b0000, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) check("ap_wrap_leds", int'(leds_of(k)), 1);
    base[0] = rd_cnt[0];
    repeat (30) run_cycle(4'b0000, 1'b0, 1'b0);
    check("ap_off_reads", rd_cnt[0] - base[0], 0);
`else
    // Without autoplay, mode has no effect.
    base[0] = rd_cnt[0];
    repeat (30) run_cycle(4'b0000, 1'b0, 1'b1);
    check("mode_ignored", rd_cnt[0] - base[0], 0);
`endif

    // Randomized phase; buttons are quiet for three cycles ahead of each reset.
    rb = '0;
    md = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 7) == 0) rb = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 39) == 0) md = !md;
      if ($urandom_range(0, 249) == 0) begin
        repeat (3) run_cycle(4'b0000, 1'b0, md);
        repeat ($urandom_range(1, 2)) run_cycle(4'b0000, 1'b1, md);
        rb = '0;
      end else begin
        run_cycle(rb, 1'b0, md);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
